// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types, constants and helpers for the bomb controller.
//   bomb_state_t : per-slot phase (IDLE, FUSE, BLAST, HOLD)
//   OFFSCREEN    : coordinate used to park an idle bomb off the visible area
//   DEF_*        : default timing/size parameters
//   abs_diff     : |a - b| on 10-bit unsigned values, no wrap
//   blast_covers : Chebyshev containment test of a point in an active blast
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2,
        HOLD  = 2'd3
    } bomb_state_t;

    localparam logic [9:0] OFFSCREEN = 10'd1023;

    localparam int DEF_FUSE_FRAMES = 120;
    localparam int DEF_BOMB_SIZE   = 6;
    localparam int DEF_BLAST_MIN   = 4;
    localparam int DEF_BLAST_MAX   = 24;
    localparam int DEF_HOLD_FRAMES = 30;

    // Larger-minus-smaller so the result never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // max(dx, dy) <= s is the same as (dx <= s) && (dy <= s).
    function automatic logic blast_covers(input bomb_state_t st,
                                          input logic [9:0]  bx,
                                          input logic [9:0]  by,
                                          input logic [9:0]  bs,
                                          input logic [9:0]  ux,
                                          input logic [9:0]  uy);
        return ((st == BLAST) || (st == HOLD)) &&
               (abs_diff(ux, bx) <= bs) && (abs_diff(uy, by) <= bs);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one player's bomb. Detects the rising edge of the drop request,
// sequences FUSE -> BLAST -> HOLD -> IDLE on frame ticks, and holds the
// frozen bomb position and drawn radius.
// Ports:
//   Clk, Reset_n         : clock, asynchronous active-low reset
//   frame_tick           : one-cycle strobe per video frame
//   drop                 : drop request level
//   user_x, user_y       : owning player's centre (latched on drop)
//   bomb_x, bomb_y       : bomb centre (OFFSCREEN when idle)
//   bomb_s               : drawn radius (0 when idle)
//   busy                 : slot is not IDLE
//   state                : current phase, used by hit detection and for debug
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES = DEF_FUSE_FRAMES,
    parameter int BOMB_SIZE   = DEF_BOMB_SIZE,
    parameter int BLAST_MIN   = DEF_BLAST_MIN,
    parameter int BLAST_MAX   = DEF_BLAST_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        drop,
    input  logic [9:0]  user_x,
    input  logic [9:0]  user_y,
    output logic [9:0]  bomb_x,
    output logic [9:0]  bomb_y,
    output logic [9:0]  bomb_s,
    output logic        busy,
    output bomb_state_t state
);

    localparam int MAX_FRAMES = (FUSE_FRAMES > HOLD_FRAMES) ? FUSE_FRAMES : HOLD_FRAMES;
    localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CW-1:0] FUSE_LOAD = CW'(FUSE_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES - 1);
    localparam logic [9:0]    S_FUSE    = 10'(BOMB_SIZE);
    localparam logic [9:0]    S_MIN     = 10'(BLAST_MIN);
    localparam logic [9:0]    S_MAX     = 10'(BLAST_MAX);

    logic          drop_q;
    logic [CW-1:0] cnt;
    logic          drop_edge;

    assign drop_edge = drop & ~drop_q;

    // Ticks in the arming cycle are never seen because the slot is still
    // IDLE then, so the fuse always counts a full FUSE_FRAMES ticks.
    // Edges outside IDLE (including the HOLD->IDLE cycle) are dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            drop_q <= 1'b0;
            cnt    <= '0;
            bomb_x <= OFFSCREEN;
            bomb_y <= OFFSCREEN;
            bomb_s <= 10'd0;
            busy   <= 1'b0;
        end else begin
            drop_q <= drop;
            case (state)
                IDLE: begin
                    if (drop_edge) begin
                        state  <= FUSE;
                        busy   <= 1'b1;
                        bomb_x <= user_x;
                        bomb_y <= user_y;
                        bomb_s <= S_FUSE;
                        cnt    <= FUSE_LOAD;
                    end
                end
                FUSE: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state  <= BLAST;
                            bomb_s <= S_MIN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                BLAST: begin
                    if (frame_tick) begin
                        if (bomb_s == S_MAX) begin
                            state <= HOLD;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            bomb_s <= bomb_s + 10'd1;
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            bomb_x <= OFFSCREEN;
                            bomb_y <= OFFSCREEN;
                            bomb_s <= 10'd0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bomb_controller.sv
// bomb_controller: two independent bomb slots (one per player) plus the
// shared blast hit detection.
// Ports:
//   Clk, Reset_n                 : clock, asynchronous active-low reset
//   frame_tick                   : one-cycle strobe per video frame
//   drop1, drop2                 : drop request levels
//   user1X/Y, user2X/Y           : player centres in pixels
//   bomb1X/Y/S, bomb2X/Y/S       : bomb centres and radii for color_mapper
//   bomb1_busy, bomb2_busy       : slot is not IDLE
//   hit1, hit2                   : one-cycle pulse, player inside any blast
module bomb_controller
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES = DEF_FUSE_FRAMES,
    parameter int BOMB_SIZE   = DEF_BOMB_SIZE,
    parameter int BLAST_MIN   = DEF_BLAST_MIN,
    parameter int BLAST_MAX   = DEF_BLAST_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       drop1,
    input  logic       drop2,
    input  logic [9:0] user1X,
    input  logic [9:0] user1Y,
    input  logic [9:0] user2X,
    input  logic [9:0] user2Y,
    output logic [9:0] bomb1X,
    output logic [9:0] bomb1Y,
    output logic [9:0] bomb1S,
    output logic [9:0] bomb2X,
    output logic [9:0] bomb2Y,
    output logic [9:0] bomb2S,
    output logic       bomb1_busy,
    output logic       bomb2_busy,
    output logic       hit1,
    output logic       hit2
);

    bomb_state_t slot1_state;
    bomb_state_t slot2_state;

    bomb_slot #(
        .FUSE_FRAMES(FUSE_FRAMES), .BOMB_SIZE(BOMB_SIZE),
        .BLAST_MIN(BLAST_MIN), .BLAST_MAX(BLAST_MAX), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_slot1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .drop(drop1),
        .user_x(user1X), .user_y(user1Y),
        .bomb_x(bomb1X), .bomb_y(bomb1Y), .bomb_s(bomb1S),
        .busy(bomb1_busy), .state(slot1_state)
    );

    bomb_slot #(
        .FUSE_FRAMES(FUSE_FRAMES), .BOMB_SIZE(BOMB_SIZE),
        .BLAST_MIN(BLAST_MIN), .BLAST_MAX(BLAST_MAX), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_slot2 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .drop(drop2),
        .user_x(user2X), .user_y(user2Y),
        .bomb_x(bomb2X), .bomb_y(bomb2Y), .bomb_s(bomb2S),
        .busy(bomb2_busy), .state(slot2_state)
    );

    // Containment uses the slot registers as they stand before the tick
    // updates them, so the check sees the radius of the frame just shown.
    logic p1_in_any;
    logic p2_in_any;

    always_comb begin
        p1_in_any = blast_covers(slot1_state, bomb1X, bomb1Y, bomb1S, user1X, user1Y) |
                    blast_covers(slot2_state, bomb2X, bomb2Y, bomb2S, user1X, user1Y);
        p2_in_any = blast_covers(slot1_state, bomb1X, bomb1Y, bomb1S, user2X, user2Y) |
                    blast_covers(slot2_state, bomb2X, bomb2Y, bomb2S, user2X, user2Y);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit1 <= 1'b0;
            hit2 <= 1'b0;
        end else begin
            hit1 <= frame_tick & p1_in_any;
            hit2 <= frame_tick & p2_in_any;
        end
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller with a frame-count reference model.
module tb_bomb_controller;

    localparam int F     = 3;
    localparam int BS    = 6;
    localparam int SMIN  = 4;
    localparam int SMAX  = 10;
    localparam int H     = 6;
    localparam int NB    = SMAX - SMIN + 1;
    localparam int TOTAL = F + NB + H;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic       frame_tick = 1'b0;
    logic       drop1 = 1'b0, drop2 = 1'b0;
    logic [9:0] user1X = '0, user1Y = '0, user2X = '0, user2Y = '0;
    logic [9:0] bomb1X, bomb1Y, bomb1S, bomb2X, bomb2Y, bomb2S;
    logic       bomb1_busy, bomb2_busy, hit1, hit2;

    bomb_controller #(
        .FUSE_FRAMES(F), .BOMB_SIZE(BS), .BLAST_MIN(SMIN),
        .BLAST_MAX(SMAX), .HOLD_FRAMES(H)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .drop1(drop1), .drop2(drop2),
        .user1X(user1X), .user1Y(user1Y), .user2X(user2X), .user2Y(user2Y),
        .bomb1X(bomb1X), .bomb1Y(bomb1Y), .bomb1S(bomb1S),
        .bomb2X(bomb2X), .bomb2Y(bomb2Y), .bomb2S(bomb2S),
        .bomb1_busy(bomb1_busy), .bomb2_busy(bomb2_busy),
        .hit1(hit1), .hit2(hit2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A bomb is "armed" plus a count of frame ticks seen since arming; the
    // phase and radius follow from that count alone.
    bit m_act[2];
    int m_t[2];
    int m_px[2], m_py[2];
    bit m_dq[2];
    bit m_hit[2];

    function automatic int model_s(input int t);
        if (t < F) return BS;
        if (t < F + NB) return SMIN + (t - F);
        return SMAX;
    endfunction

    function automatic bit inside_blast(input int k, input int ux, input int uy);
        int dx, dy, s;
        if (!m_act[k] || m_t[k] < F) return 1'b0;
        s  = model_s(m_t[k]);
        dx = (ux > m_px[k]) ? ux - m_px[k] : m_px[k] - ux;
        dy = (uy > m_py[k]) ? uy - m_py[k] : m_py[k] - uy;
        return (dx <= s) && (dy <= s);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_t[k] = 0; m_px[k] = 1023; m_py[k] = 1023;
            m_dq[k] = 0; m_hit[k] = 0;
        end
    endtask

    task automatic model_step();
        bit d[2];
        int ux[2], uy[2];
        d[0] = drop1;  d[1] = drop2;
        ux[0] = int'(user1X); uy[0] = int'(user1Y);
        ux[1] = int'(user2X); uy[1] = int'(user2Y);
        for (int p = 0; p < 2; p++)
            m_hit[p] = frame_tick && (inside_blast(0, ux[p], uy[p]) || inside_blast(1, ux[p], uy[p]));
        for (int k = 0; k < 2; k++) begin
            if (!m_act[k]) begin
                if (d[k] && !m_dq[k]) begin
                    m_act[k] = 1; m_t[k] = 0; m_px[k] = ux[k]; m_py[k] = uy[k];
                end
            end else if (frame_tick) begin
                m_t[k]++;
                if (m_t[k] == TOTAL) m_act[k] = 0;
            end
            m_dq[k] = d[k];
        end
    endtask

    task automatic check_all();
        check("bomb1X", int'(bomb1X), m_act[0] ? m_px[0] : 1023);
        check("bomb1Y", int'(bomb1Y), m_act[0] ? m_py[0] : 1023);
        check("bomb1S", int'(bomb1S), m_act[0] ? model_s(m_t[0]) : 0);
        check("bomb2X", int'(bomb2X), m_act[1] ? m_px[1] : 1023);
        check("bomb2Y", int'(bomb2Y), m_act[1] ? m_py[1] : 1023);
        check("bomb2S", int'(bomb2S), m_act[1] ? model_s(m_t[1]) : 0);
        check("busy1", int'(bomb1_busy), int'(m_act[0]));
        check("busy2", int'(bomb2_busy), int'(m_act[1]));
        check("hit1", int'(hit1), int'(m_hit[0]));
        check("hit2", int'(hit2), int'(m_hit[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit tick);
        frame_tick = tick;
        model_step();
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        check_all();
    endtask

    task automatic frame();
        cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((m_act[0] || m_act[1]) && n < 200) begin
            frame();
            n++;
        end
        check("idle_timeout", int'(m_act[0] || m_act[1]), 0);
    endtask

    task automatic run_until_t(input int k, input int target);
        int n = 0;
        while (m_act[k] && m_t[k] != target && n < 200) begin
            frame();
            n++;
        end
        check("reach_t_timeout", m_t[k], target);
    endtask

    function automatic logic [9:0] clip(input int v);
        if (v < 0) return 10'd0;
        if (v > 1023) return 10'd1023;
        return 10'(v);
    endfunction

    // ---------------- vector table for the hit boundary ----------------
    typedef struct {
        logic [9:0] ux;
        logic [9:0] uy;
        logic       exp_hit;
    } hit_vec_t;

    hit_vec_t vecs[6];

    initial begin
        int n;
        int base[3];
        base[0] = 5; base[1] = 300; base[2] = 1018;

        vecs[0] = '{10'd310, 10'd295, 1'b1};
        vecs[1] = '{10'd311, 10'd300, 1'b0};
        vecs[2] = '{10'd290, 10'd290, 1'b1};
        vecs[3] = '{10'd289, 10'd300, 1'b0};
        vecs[4] = '{10'd300, 10'd310, 1'b1};
        vecs[5] = '{10'd305, 10'd289, 1'b0};

        // reset state
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        check_all();
        check("rst_bomb1X", int'(bomb1X), 1023);
        check("rst_bomb2S", int'(bomb2S), 0);

        // drop1 at (100,200), held high for the whole bomb; player moves
        user1X = 10'd100; user1Y = 10'd200;
        drop1 = 1'b1;
        cycle(1'b0);
        check("arm_busy1", int'(bomb1_busy), 1);
        check("arm_S1", int'(bomb1S), BS);
        n = 0;
        while (bomb1_busy && n < 100) begin
            user1X = user1X + 10'd3;
            if (m_t[0] == F + 2) begin
                drop1 = 1'b0; cycle(1'b0);
                drop1 = 1'b1; cycle(1'b0);
            end
            frame();
            n++;
        end
        check("bomb_len_frames", n, TOTAL);
        repeat (4) frame();
        check("held_no_rearm", int'(bomb1_busy), 0);
        drop1 = 1'b0;
        cycle(1'b0);

        // async reset in the middle of the fuse
        user1X = 10'd100; user1Y = 10'd200;
        drop1 = 1'b1;
        cycle(1'b0);
        drop1 = 1'b0;
        frame();
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy1", int'(bomb1_busy), 0);
        check("arst_bomb1X", int'(bomb1X), 1023);
        check("arst_bomb1S", int'(bomb1S), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cycle(1'b0);

        // hit boundary table: bomb2 at (300,300) held at S=10
        user2X = 10'd300; user2Y = 10'd300;
        user1X = 10'd900; user1Y = 10'd900;
        drop2 = 1'b1;
        cycle(1'b0);
        drop2 = 1'b0;
        user2X = 10'd700; user2Y = 10'd700;
        run_until_t(1, F + NB);
        for (int i = 0; i < 6; i++) begin
            user1X = vecs[i].ux; user1Y = vecs[i].uy;
            cycle(1'b1);
            check("tbl_hit1", int'(hit1), int'(vecs[i].exp_hit));
            cycle(1'b0);
            check("tbl_hit1_pulse", int'(hit1), 0);
        end
        run_until_idle();

        // own bomb during the first blast frame
        user2X = 10'd300; user2Y = 10'd300;
        user1X = 10'd900; user1Y = 10'd100;
        drop2 = 1'b1;
        cycle(1'b0);
        drop2 = 1'b0;
        run_until_t(1, F);
        cycle(1'b1);
        check("own_hit2", int'(hit2), 1);
        check("own_far_hit1", int'(hit1), 0);
        run_until_idle();

        // simultaneous drops on a tick cycle
        drop1 = 1'b1; drop2 = 1'b1;
        cycle(1'b1);
        check("sim_busy1", int'(bomb1_busy), 1);
        check("sim_busy2", int'(bomb2_busy), 1);
        drop1 = 1'b0; drop2 = 1'b0;
        n = 0;
        while (int'(bomb1S) == BS && n < 20) begin
            frame();
            n++;
        end
        check("fuse_len", n, F);
        check("fuse_end_S2", int'(bomb2S), SMIN);
        run_until_idle();

        // drop edge coinciding with HOLD->IDLE
        drop1 = 1'b1;
        cycle(1'b0);
        drop1 = 1'b0;
        run_until_t(0, TOTAL - 1);
        cycle(1'b0);
        drop1 = 1'b1;
        cycle(1'b1);
        check("edge_at_end_busy1", int'(bomb1_busy), 0);
        cycle(1'b0);
        check("edge_at_end_still_idle", int'(bomb1_busy), 0);
        drop1 = 1'b0;
        cycle(1'b0);
        drop1 = 1'b1;
        cycle(1'b0);
        check("rearm_busy1", int'(bomb1_busy), 1);
        drop1 = 1'b0;
        run_until_idle();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) drop1 = ~drop1;
            if ($urandom_range(0, 7) == 0) drop2 = ~drop2;
            if ($urandom_range(0, 15) == 0) begin
                n = base[$urandom_range(0, 2)];
                user1X = clip(n + int'($urandom_range(0, 30)) - 15);
                user1Y = clip(n + int'($urandom_range(0, 30)) - 15);
            end
            if ($urandom_range(0, 15) == 0) begin
                n = base[$urandom_range(0, 2)];
                user2X = clip(n + int'($urandom_range(0, 30)) - 15);
                user2Y = clip(n + int'($urandom_range(0, 30)) - 15);
            end
            cycle($urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Sequences both players' bombs through fuse, blast and hold phases, and drives the `bomb1X/Y/S` and `bomb2X/Y/S` inputs of `color_mapper`. It also reports when a player's centre lies inside an active blast. All timing is in frames, counted on a one-cycle `frame_tick` strobe from the VGA timing logic. It sits between the keyboard/player-motion logic and `color_mapper`.

## Interface
Parameters:
- `FUSE_FRAMES`, 120: frames from drop to blast start; must be ≥1.
- `BOMB_SIZE`, 6: drawn radius during the fuse.
- `BLAST_MIN`, 4: radius on the first blast frame.
- `BLAST_MAX`, 24: final radius; `BLAST_MIN` ≤ `BLAST_MAX` ≤ 1022.
- `HOLD_FRAMES`, 30: frames the blast holds at `BLAST_MAX`; must be ≥1.

Ports:
- `Clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `Reset_n` in 1: asynchronous active-low reset.
- `frame_tick` in 1: one-`Clk` pulse per frame.
- `drop1`, `drop2` in 1: drop-bomb request level from the keyboard decoder.
- `user1X`, `user1Y`, `user2X`, `user2Y` in 10 each: player centres, in pixels.
- `bomb1X`, `bomb1Y`, `bomb1S` out 10 each: bomb 1 centre and radius, to `color_mapper`.
- `bomb2X`, `bomb2Y`, `bomb2S` out 10 each: same for bomb 2.
- `bomb1_busy`, `bomb2_busy` out 1: slot is not IDLE.
- `hit1`, `hit2` out 1: one-cycle pulse when player N is inside any blast.

## Operation
- There are two identical, independent slots. Slot N is owned by player N.
- Each slot has states IDLE, FUSE, BLAST and HOLD.
- IDLE:
  - `bombNX` = `bombNY` = 1023 (OFFSCREEN) and `bombNS` = 0. This keeps a zero radius from drawing a visible pixel.
  - A rising edge on `dropN` (`dropN` & ~`dropN_q`, where `dropN_q` is a registered copy) moves the slot to FUSE.
  - On that move the slot latches `userNX/Y` into the bomb position and loads the counter with `FUSE_FRAMES-1`.
- FUSE:
  - S = `BOMB_SIZE`.
  - On each `frame_tick`: if counter = 0, go to BLAST with S = `BLAST_MIN`; otherwise decrement the counter.
- BLAST:
  - On each `frame_tick`: if S = `BLAST_MAX`, go to HOLD and load the counter with `HOLD_FRAMES-1`; otherwise S += 1.
- HOLD:
  - S = `BLAST_MAX`.
  - On each `frame_tick`: if counter = 0, go to IDLE; otherwise decrement the counter.
- Drop edges in any non-IDLE state are ignored and not queued.
- The bomb position is frozen from drop until return to IDLE.
- Hit detection, evaluated only on `frame_tick` cycles:
  - For every slot in BLAST or HOLD, and for each player P: dx = |userPX − bombX| and dy = |userPY − bombY|, both 10-bit unsigned. Use the subtraction in the larger-minus-smaller direction; no wrap.
  - Player P is hit if max(dx, dy) ≤ S (Chebyshev distance; no multipliers).
  - `hitP` = OR over both slots. A player's own bomb counts.
- Arithmetic: all comparisons are unsigned 10-bit. Counter width is `$clog2(max(FUSE_FRAMES, HOLD_FRAMES))`, minimum 1.

## Timing
- Reset (async, while `Reset_n` = 0): both slots go to IDLE, X = Y = 1023, S = 0, counters = 0, `dropN_q` = 0, busy = 0, hit = 0. Reset mid-operation aborts any bomb immediately.
- All outputs are registered.
- Drop-to-busy latency: the drop edge is seen in cycle t. In cycle t+1, `busyN` = 1, the position is valid and S = `BOMB_SIZE`.
- If `frame_tick` coincides with the drop-edge cycle, it is not counted. The FUSE still lasts exactly `FUSE_FRAMES` ticks.
- Phase lengths in ticks: FUSE = `FUSE_FRAMES`; BLAST = `BLAST_MAX−BLAST_MIN+1`; HOLD = `HOLD_FRAMES`. State and S update in the cycle after the tick.
- Hit evaluation uses the state and S registered before the tick. Pulse timing:
  - `hitP` goes high in the cycle after `frame_tick` and lasts exactly 1 cycle.
  - The first-frame blast check occurs on the first tick after BLAST is entered.
- A drop edge in the same cycle as the HOLD→IDLE transition is ignored; the player must re-press.
- Simultaneous drops by both players are independent; both slots arm in the same cycle.

## Structure
- `bomb_pkg` holds:
  - `bomb_state_t` enum {IDLE, FUSE, BLAST, HOLD}.
  - `OFFSCREEN` = 10'd1023.
  - Default parameter constants.
- Sub-module `bomb_slot` contains the edge detect, FSM, counter, latched position and S register. It is instantiated twice.
- `bomb_controller` contains the two instances plus the shared hit-detect logic and its output registers.

## Test plan
1. Reset mid-FUSE (deassert `Reset_n` asynchronously):
   - Stimulus: FUSE_FRAMES = 3, BLAST 4..6, HOLD_FRAMES = 2. Drop1 with user1 = (100,200).
   - Required response: bomb1 = (100,200,6) for 3 ticks; S = 4, 5, 6 at one tick each; S = 6 for 2 more ticks; then (1023,1023,0) with busy1 = 0.
   - Reset mid-FUSE returns all outputs to reset values within the same cycle.
2. Hold `drop1` high continuously through a full bomb:
   - Required response: only one bomb. A second press during BLAST is ignored, and `bomb1X/Y` do not follow user1 motion.
3. Hit boundary, with bomb2 at (300,300) and S = 10 in HOLD:
   - user1 = (310,295) → `hit1` pulses for 1 cycle after the tick.
   - user1 = (311,300) → no pulse.
4. Own bomb in BLAST: user2 = (300,300) → `hit2` = 1, and `hit1` = 0 if user1 is far away.
5. Drop1 and drop2 edges in the same cycle, coincident with `frame_tick`:
   - Required response: both busy next cycle. Each FUSE lasts the full `FUSE_FRAMES` ticks.
6. Drop edge in the HOLD→IDLE cycle:
   - Required response: ignored; slot stays IDLE. The next edge arms it.
